// File: rtl/wb_stage_pipe_if.sv
// Handshake and datapath bundle between the MEM stage and the writeback stage,
// including the register-file write / forwarding outputs and the retire counter.
interface wb_stage_pipe_if #(
  parameter int XLEN  = 32,
  parameter int RF_AW = 5,
  parameter int CNT_W = 64
);
  localparam int AL_W = (XLEN == 64) ? 3 : 2;

  logic             in_valid;
  logic             in_ready;
  logic             flush;
  logic [XLEN-1:0]  pc4;
  logic [XLEN-1:0]  alu_result;
  logic [XLEN-1:0]  csr_rdata;
  logic [1:0]       mem_to_reg;
  logic             reg_write;
  logic [RF_AW-1:0] rd;
  logic [2:0]       load_funct3;
  logic [AL_W-1:0]  addr_lo;
  logic             mem_rvalid;
  logic [XLEN-1:0]  mem_rdata;
  logic             rf_we;
  logic [RF_AW-1:0] rf_waddr;
  logic [XLEN-1:0]  rf_wdata;
  logic             load_err;
  logic [CNT_W-1:0] instret;

  modport master (
    output in_valid, flush, pc4, alu_result, csr_rdata, mem_to_reg, reg_write, rd,
           load_funct3, addr_lo, mem_rvalid, mem_rdata,
    input  in_ready, rf_we, rf_waddr, rf_wdata, load_err, instret
  );

  modport slave (
    input  in_valid, flush, pc4, alu_result, csr_rdata, mem_to_reg, reg_write, rd,
           load_funct3, addr_lo, mem_rvalid, mem_rdata,
    output in_ready, rf_we, rf_waddr, rf_wdata, load_err, instret
  );
endinterface

// File: rtl/wb_stage_pipe.sv
// Writeback stage: selects the result source, formats load data, stalls for
// late memory responses, drives the register-file write / forwarding bus and instret.
module wb_stage_pipe #(
  parameter int XLEN  = 32,
  parameter int RF_AW = 5,
  parameter int CNT_W = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  wb_stage_pipe_if.slave  bus
);
  localparam int AL_W = (XLEN == 64) ? 3 : 2;

  // state    | meaning
  // IDLE     | ready for a new instruction
  // WAIT_MEM | holding a load whose data has not yet arrived
  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] WAIT_MEM = 1'b1;

  localparam logic [1:0] SRC_PC4 = 2'd0;
  localparam logic [1:0] SRC_MEM = 2'd1;
  localparam logic [1:0] SRC_ALU = 2'd2;
  localparam logic [1:0] SRC_CSR = 2'd3;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  logic [0:0]       state_q, state_d;
  logic [XLEN-1:0]  h_pc4_q, h_pc4_d;
  logic [XLEN-1:0]  h_alu_q, h_alu_d;
  logic [XLEN-1:0]  h_csr_q, h_csr_d;
  logic [1:0]       h_m2r_q, h_m2r_d;
  logic             h_rw_q, h_rw_d;
  logic [RF_AW-1:0] h_rd_q, h_rd_d;
  logic [2:0]       h_f3_q, h_f3_d;
  logic [AL_W-1:0]  h_alo_q, h_alo_d;

  logic             rf_we_q, rf_we_d;
  logic [RF_AW-1:0] rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]  rf_wdata_q, rf_wdata_d;
  logic             load_err_q, load_err_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  logic [XLEN-1:0]  s_pc4, s_alu, s_csr;
  logic [1:0]       s_m2r;
  logic             s_rw;
  logic [RF_AW-1:0] s_rd;
  logic [2:0]       s_f3;
  logic [AL_W-1:0]  s_alo;

  logic             in_ready, accept, mem_ok, commit, go_wait, err;
  logic [XLEN-1:0]  lane, ld_val, src_val;
  logic             ld_err;

  // The instruction being worked on: held copy while waiting, live inputs otherwise.
  always_comb begin
    if (state_q == WAIT_MEM) begin
      s_pc4 = h_pc4_q;
      s_alu = h_alu_q;
      s_csr = h_csr_q;
      s_m2r = h_m2r_q;
      s_rw  = h_rw_q;
      s_rd  = h_rd_q;
      s_f3  = h_f3_q;
      s_alo = h_alo_q;
    end else begin
      s_pc4 = bus.pc4;
      s_alu = bus.alu_result;
      s_csr = bus.csr_rdata;
      s_m2r = bus.mem_to_reg;
      s_rw  = bus.reg_write;
      s_rd  = bus.rd;
      s_f3  = bus.load_funct3;
      s_alo = bus.addr_lo;
    end
  end

  always_comb begin
    lane   = bus.mem_rdata >> {s_alo, 3'b000};
    ld_val = lane;
    ld_err = 1'b0;
    case (s_f3)
      F3_LB: begin
        ld_val      = {XLEN{lane[7]}};
        ld_val[7:0] = lane[7:0];
      end
      F3_LBU: begin
        ld_val      = '0;
        ld_val[7:0] = lane[7:0];
      end
      F3_LH: begin
        ld_val       = {XLEN{lane[15]}};
        ld_val[15:0] = lane[15:0];
        ld_err       = s_alo[0];
      end
      F3_LHU: begin
        ld_val       = '0;
        ld_val[15:0] = lane[15:0];
        ld_err       = s_alo[0];
      end
      F3_LW: begin
        ld_val       = {XLEN{lane[31]}};
        ld_val[31:0] = lane[31:0];
        ld_err       = |s_alo[1:0];
      end
      F3_LWU: begin
        ld_val       = '0;
        ld_val[31:0] = lane[31:0];
        ld_err       = (XLEN == 32) || (|s_alo[1:0]);
      end
      F3_LD: begin
        ld_val = lane;
        ld_err = (XLEN == 32) || (|s_alo);
      end
      default: ld_err = 1'b1;
    endcase
  end

  always_comb begin
    case (s_m2r)
      SRC_PC4: src_val = s_pc4;
      SRC_MEM: src_val = ld_val;
      SRC_ALU: src_val = s_alu;
      SRC_CSR: src_val = s_csr;
      default: src_val = s_alu;
    endcase
    err = (s_m2r == SRC_MEM) && ld_err;
  end

  // Flush overrides both the memory response and any commit.
  always_comb begin
    in_ready = (state_q == IDLE);
    accept   = bus.in_valid && in_ready;
    mem_ok   = (s_m2r != SRC_MEM) || bus.mem_rvalid;
    commit   = !bus.flush && (accept || (state_q == WAIT_MEM)) && mem_ok;
    go_wait  = !bus.flush && accept && !mem_ok;

    state_d = state_q;
    if (bus.flush)    state_d = IDLE;
    else if (go_wait) state_d = WAIT_MEM;
    else if (commit)  state_d = IDLE;

    h_pc4_d = h_pc4_q;
    h_alu_d = h_alu_q;
    h_csr_d = h_csr_q;
    h_m2r_d = h_m2r_q;
    h_rw_d  = h_rw_q;
    h_rd_d  = h_rd_q;
    h_f3_d  = h_f3_q;
    h_alo_d = h_alo_q;
    if (go_wait) begin
      h_pc4_d = bus.pc4;
      h_alu_d = bus.alu_result;
      h_csr_d = bus.csr_rdata;
      h_m2r_d = bus.mem_to_reg;
      h_rw_d  = bus.reg_write;
      h_rd_d  = bus.rd;
      h_f3_d  = bus.load_funct3;
      h_alo_d = bus.addr_lo;
    end

    rf_we_d    = commit && s_rw && (s_rd != '0) && !err;
    rf_waddr_d = commit ? s_rd : rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (commit) rf_wdata_d = (s_rd == '0) ? '0 : src_val;
    load_err_d = commit && err;
    instret_d  = instret_q + CNT_W'(commit && !err);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      h_pc4_q    <= '0;
      h_alu_q    <= '0;
      h_csr_q    <= '0;
      h_m2r_q    <= '0;
      h_rw_q     <= 1'b0;
      h_rd_q     <= '0;
      h_f3_q     <= '0;
      h_alo_q    <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      load_err_q <= 1'b0;
      instret_q  <= '0;
    end else begin
      state_q    <= state_d;
      h_pc4_q    <= h_pc4_d;
      h_alu_q    <= h_alu_d;
      h_csr_q    <= h_csr_d;
      h_m2r_q    <= h_m2r_d;
      h_rw_q     <= h_rw_d;
      h_rd_q     <= h_rd_d;
      h_f3_q     <= h_f3_d;
      h_alo_q    <= h_alo_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      load_err_q <= load_err_d;
      instret_q  <= instret_d;
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.rf_we    = rf_we_q;
  assign bus.rf_waddr = rf_waddr_q;
  assign bus.rf_wdata = rf_wdata_q;
  assign bus.load_err = load_err_q;
  assign bus.instret  = instret_q;
endmodule
